// File: rtl/rv_lsu_pkg.sv
// -----------------------------------------------------------------------------
// rv_lsu_pkg
// Shared types and constants for the load/store unit store path.
//   sz_e     : access size encoding as it arrives from the core (st_size_i)
//   state_e  : store sequencer states
//   LANES    : number of byte lanes in a data word
// -----------------------------------------------------------------------------
package rv_lsu_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } sz_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ1 = 3'd1,
        ST_RSP1 = 3'd2,
        ST_REQ2 = 3'd3,
        ST_RSP2 = 3'd4
    } state_e;

endpackage

// File: rtl/rv_store_lane_align.sv
// -----------------------------------------------------------------------------
// rv_store_lane_align
// Combinational lane placement for stores. The result spans two words so that a
// store crossing a word boundary can be issued as two accesses: bits [3:0] /
// [31:0] form the first access, bits [7:4] / [63:32] the second.
//   off_i   : byte offset within the word (addr[1:0])
//   size_i  : access size
//   data_i  : register value, low bits used for byte/half
//   be_o    : byte enables over two words
//   wdata_o : lane-placed write data over two words, unused lanes zero
// -----------------------------------------------------------------------------
module rv_store_lane_align
    import rv_lsu_pkg::*;
(
    input  logic [1:0]  off_i,
    input  sz_e         size_i,
    input  logic [31:0] data_i,
    output logic [7:0]  be_o,
    output logic [63:0] wdata_o
);

    logic [7:0]  mask_s;
    logic [31:0] narrow_s;

    // Size decode: lane mask and data narrowed to the access width.
    always_comb begin
        mask_s   = 8'h00;
        narrow_s = 32'h0000_0000;
        case (size_i)
            SZ_BYTE: begin
                mask_s   = 8'h01;
                narrow_s = {24'h00_0000, data_i[7:0]};
            end
            SZ_HALF: begin
                mask_s   = 8'h03;
                narrow_s = {16'h0000, data_i[15:0]};
            end
            SZ_WORD: begin
                mask_s   = 8'h0F;
                narrow_s = data_i;
            end
            default: begin
                mask_s   = 8'h00;
                narrow_s = 32'h0000_0000;
            end
        endcase
    end

    // Shift mask and data up to the addressed lanes.
    always_comb begin
        be_o    = mask_s << off_i;
        wdata_o = {32'h0000_0000, narrow_s} << {off_i, 3'b000};
    end

endmodule

// File: rtl/rv_store_align.sv
// -----------------------------------------------------------------------------
// rv_store_align
// Store issue unit: narrows a register value to byte/half/word, places it on
// the byte lanes, and runs the req/gnt/rvalid handshake to data memory.
// Optional macro RV_STORE_MISALIGN_EN: accept any alignment and split
// word-crossing stores into two accesses. Without it, misaligned half/word
// stores are rejected with st_err_o and the second access path is not built.
// Ports:
//   clk_i, arstn_i          : clock, async active-low reset
//   st_valid_i/st_ready_o   : store request from core / unit idle
//   st_addr_i/st_data_i     : byte address / register value
//   st_size_i               : 00 byte, 01 half, 10 word, 11 illegal
//   st_done_o/st_err_o      : one-cycle completion / rejection pulses
//   data_req_o/data_gnt_i   : memory request / grant
//   data_rvalid_i           : memory write response
//   data_we_o               : write enable, follows data_req_o
//   data_addr_o/be_o/wdata_o: word-aligned address, byte enables, write data
// -----------------------------------------------------------------------------
module rv_store_align
    import rv_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int XLEN       = 32
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  st_valid_i,
    output logic                  st_ready_o,
    input  logic [ADDR_WIDTH-1:0] st_addr_i,
    input  logic [XLEN-1:0]       st_data_i,
    input  logic [1:0]            st_size_i,
    output logic                  st_done_o,
    output logic                  st_err_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic                  data_we_o,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic [LANES-1:0]      data_be_o,
    output logic [XLEN-1:0]       data_wdata_o
);

    sz_e                   size_s;
    logic [7:0]            be8_s;
    logic [63:0]           wd64_s;
    logic                  illegal_s;
    logic                  misal_s;

    state_e                state_q,      state_d;
    logic                  st_ready_q,   st_ready_d;
    logic                  st_done_q,    st_done_d;
    logic                  st_err_q,     st_err_d;
    logic                  data_req_q,   data_req_d;
    logic [ADDR_WIDTH-1:0] data_addr_q,  data_addr_d;
    logic [LANES-1:0]      data_be_q,    data_be_d;
    logic [XLEN-1:0]       data_wdata_q, data_wdata_d;

    assign size_s = sz_e'(st_size_i);

    rv_store_lane_align u_lane (
        .off_i   (st_addr_i[1:0]),
        .size_i  (size_s),
        .data_i  (st_data_i),
        .be_o    (be8_s),
        .wdata_o (wd64_s)
    );

    assign illegal_s = (size_s == SZ_ILL);

`ifdef RV_STORE_MISALIGN_EN
    // Second-access payload captured at accept time.
    logic                  cross_q,  cross_d;
    logic [LANES-1:0]      be_hi_q,  be_hi_d;
    logic [XLEN-1:0]       wd_hi_q,  wd_hi_d;

    // Every alignment is legal; crossing stores are split.
    always_comb begin
        misal_s = 1'b0;
    end
`else
    // Upper half of the lane result only matters for split stores.
    logic unused_hi_s;
    assign unused_hi_s = ^{be8_s[7:4], wd64_s[63:32]};

    // Reject half on odd address and word on any non-zero offset.
    always_comb begin
        misal_s = 1'b0;
        if (size_s == SZ_HALF) begin
            misal_s = st_addr_i[0];
        end else if (size_s == SZ_WORD) begin
            misal_s = |st_addr_i[1:0];
        end else begin
            misal_s = 1'b0;
        end
    end
`endif

    // Next-state and output-register computation for the store sequencer.
    always_comb begin
        state_d      = state_q;
        st_done_d    = 1'b0;
        st_err_d     = 1'b0;
        data_req_d   = data_req_q;
        data_addr_d  = data_addr_q;
        data_be_d    = data_be_q;
        data_wdata_d = data_wdata_q;
`ifdef RV_STORE_MISALIGN_EN
        cross_d      = cross_q;
        be_hi_d      = be_hi_q;
        wd_hi_d      = wd_hi_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // st_ready_q is low during the done/err pulse cycle, so a
                // request then waits one more cycle.
                if (st_valid_i && st_ready_q) begin
                    if (illegal_s || misal_s) begin
                        st_err_d = 1'b1;
                    end else begin
                        state_d      = ST_REQ1;
                        data_req_d   = 1'b1;
                        data_addr_d  = {st_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        data_be_d    = be8_s[3:0];
                        data_wdata_d = wd64_s[31:0];
`ifdef RV_STORE_MISALIGN_EN
                        cross_d      = |be8_s[7:4];
                        be_hi_d      = be8_s[7:4];
                        wd_hi_d      = wd64_s[63:32];
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ1: begin
                if (data_gnt_i) begin
                    state_d    = ST_RSP1;
                    data_req_d = 1'b0;
                end else begin
                    state_d = ST_REQ1;
                end
            end
            ST_RSP1: begin
                if (data_rvalid_i) begin
`ifdef RV_STORE_MISALIGN_EN
                    if (cross_q) begin
                        state_d      = ST_REQ2;
                        data_req_d   = 1'b1;
                        data_addr_d  = data_addr_q + ADDR_WIDTH'(4);
                        data_be_d    = be_hi_q;
                        data_wdata_d = wd_hi_q;
                    end else
`endif
                    begin
                        state_d   = ST_IDLE;
                        st_done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_RSP1;
                end
            end
`ifdef RV_STORE_MISALIGN_EN
            ST_REQ2: begin
                if (data_gnt_i) begin
                    state_d    = ST_RSP2;
                    data_req_d = 1'b0;
                end else begin
                    state_d = ST_REQ2;
                end
            end
            ST_RSP2: begin
                if (data_rvalid_i) begin
                    state_d   = ST_IDLE;
                    st_done_d = 1'b1;
                end else begin
                    state_d = ST_RSP2;
                end
            end
`endif
            default: begin
                state_d    = ST_IDLE;
                data_req_d = 1'b0;
            end
        endcase
        // Ready stays low through the pulse cycle and returns the cycle after.
        st_ready_d = (state_d == ST_IDLE) && !st_done_d && !st_err_d;
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q      <= ST_IDLE;
            st_ready_q   <= 1'b1;
            st_done_q    <= 1'b0;
            st_err_q     <= 1'b0;
            data_req_q   <= 1'b0;
            data_addr_q  <= {ADDR_WIDTH{1'b0}};
            data_be_q    <= {LANES{1'b0}};
            data_wdata_q <= {XLEN{1'b0}};
        end else begin
            state_q      <= state_d;
            st_ready_q   <= st_ready_d;
            st_done_q    <= st_done_d;
            st_err_q     <= st_err_d;
            data_req_q   <= data_req_d;
            data_addr_q  <= data_addr_d;
            data_be_q    <= data_be_d;
            data_wdata_q <= data_wdata_d;
        end
    end

`ifdef RV_STORE_MISALIGN_EN
    // Second-access payload registers.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            cross_q <= 1'b0;
            be_hi_q <= {LANES{1'b0}};
            wd_hi_q <= {XLEN{1'b0}};
        end else begin
            cross_q <= cross_d;
            be_hi_q <= be_hi_d;
            wd_hi_q <= wd_hi_d;
        end
    end
`endif

    assign st_ready_o   = st_ready_q;
    assign st_done_o    = st_done_q;
    assign st_err_o     = st_err_q;
    assign data_req_o   = data_req_q;
    assign data_we_o    = data_req_q;
    assign data_addr_o  = data_addr_q;
    assign data_be_o    = data_be_q;
    assign data_wdata_o = data_wdata_q;

endmodule

// File: tb/tb_rv_store_align.sv
// -----------------------------------------------------------------------------
// tb_rv_store_align
// Directed bench for rv_store_align. Inputs change and outputs are sampled
// 1ns after the rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_rv_store_align;

    logic        clk = 1'b0;
    logic        arstn;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        st_done;
    logic        st_err;
    logic        data_req;
    logic        data_gnt;
    logic        data_rvalid;
    logic        data_we;
    logic [31:0] data_addr;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv_store_align #(
        .ADDR_WIDTH (32),
        .XLEN       (32)
    ) dut (
        .clk_i         (clk),
        .arstn_i       (arstn),
        .st_valid_i    (st_valid),
        .st_ready_o    (st_ready),
        .st_addr_i     (st_addr),
        .st_data_i     (st_data),
        .st_size_i     (st_size),
        .st_done_o     (st_done),
        .st_err_o      (st_err),
        .data_req_o    (data_req),
        .data_gnt_i    (data_gnt),
        .data_rvalid_i (data_rvalid),
        .data_we_o     (data_we),
        .data_addr_o   (data_addr),
        .data_be_o     (data_be),
        .data_wdata_o  (data_wdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One store transaction; memory grants after gnt_wait stall cycles and
    // responds in the cycle after the grant.
    task automatic run_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] size, input int gnt_wait, input bit exp_err,
                             input int nacc,
                             input logic [31:0] a1, input logic [3:0] b1, input logic [31:0] w1,
                             input logic [31:0] a2, input logic [3:0] b2, input logic [31:0] w2,
                             input bit poke_rsp);
        logic [31:0] ea;
        logic [3:0]  eb;
        logic [31:0] ew;
        check_eq({tag, ".ready_idle"}, 32'(st_ready), 32'd1);
        st_valid = 1'b1;
        st_addr  = addr;
        st_data  = data;
        st_size  = size;
        step();
        st_valid = 1'b0;
        if (exp_err) begin
            check_eq({tag, ".err_pulse"}, 32'(st_err), 32'd1);
            check_eq({tag, ".err_ready"}, 32'(st_ready), 32'd0);
            check_eq({tag, ".err_noreq"}, 32'(data_req), 32'd0);
            step();
            check_eq({tag, ".err_drop"}, 32'(st_err), 32'd0);
            check_eq({tag, ".err_ready_back"}, 32'(st_ready), 32'd1);
            check_eq({tag, ".err_noreq2"}, 32'(data_req), 32'd0);
            return;
        end
        for (int a = 0; a < nacc; a++) begin
            ea = (a == 0) ? a1 : a2;
            eb = (a == 0) ? b1 : b2;
            ew = (a == 0) ? w1 : w2;
            for (int w = 0; w <= gnt_wait; w++) begin
                check_eq({tag, ".req"}, 32'(data_req), 32'd1);
                check_eq({tag, ".we"}, 32'(data_we), 32'd1);
                check_eq({tag, ".addr"}, data_addr, ea);
                check_eq({tag, ".be"}, 32'(data_be), 32'(eb));
                check_eq({tag, ".wdata"}, data_wdata, ew);
                check_eq({tag, ".ready_busy"}, 32'(st_ready), 32'd0);
                check_eq({tag, ".no_early_done"}, 32'(st_done), 32'd0);
                data_gnt = (w == gnt_wait);
                step();
            end
            data_gnt = 1'b0;
            check_eq({tag, ".req_drop"}, 32'(data_req), 32'd0);
            check_eq({tag, ".rsp_nodone"}, 32'(st_done), 32'd0);
            if (poke_rsp && a == 0) begin
                st_valid = 1'b1;
                st_addr  = 32'h0000_7000;
                st_size  = 2'b00;
                check_eq({tag, ".rsp_ready"}, 32'(st_ready), 32'd0);
            end
            data_rvalid = 1'b1;
            step();
            data_rvalid = 1'b0;
            st_valid    = 1'b0;
        end
        check_eq({tag, ".done"}, 32'(st_done), 32'd1);
        check_eq({tag, ".done_ready"}, 32'(st_ready), 32'd0);
        check_eq({tag, ".done_noreq"}, 32'(data_req), 32'd0);
        step();
        check_eq({tag, ".done_drop"}, 32'(st_done), 32'd0);
        check_eq({tag, ".ready_back"}, 32'(st_ready), 32'd1);
        check_eq({tag, ".no_new_req"}, 32'(data_req), 32'd0);
        check_eq({tag, ".no_err"}, 32'(st_err), 32'd0);
    endtask

    initial begin
        arstn       = 1'b0;
        st_valid    = 1'b0;
        st_addr     = 32'h0;
        st_data     = 32'h0;
        st_size     = 2'b00;
        data_gnt    = 1'b0;
        data_rvalid = 1'b0;
        step();
        check_eq("rst.ready", 32'(st_ready), 32'd1);
        check_eq("rst.done", 32'(st_done), 32'd0);
        check_eq("rst.err", 32'(st_err), 32'd0);
        check_eq("rst.req", 32'(data_req), 32'd0);
        check_eq("rst.we", 32'(data_we), 32'd0);
        check_eq("rst.addr", data_addr, 32'h0);
        check_eq("rst.be", 32'(data_be), 32'h0);
        check_eq("rst.wdata", data_wdata, 32'h0);
        arstn = 1'b1;
        step();

        // Stray response while idle must be ignored.
        data_rvalid = 1'b1;
        step();
        data_rvalid = 1'b0;
        check_eq("stray.done", 32'(st_done), 32'd0);
        check_eq("stray.ready", 32'(st_ready), 32'd1);

        run_store("byte", 32'h0000_1003, 32'hDEAD_BEEF, 2'b00, 0, 1'b0, 1,
                  32'h0000_1000, 4'b1000, 32'hEF00_0000, 32'h0, 4'b0000, 32'h0, 1'b0);
        run_store("half", 32'h0000_2002, 32'h0000_A5C3, 2'b01, 3, 1'b0, 1,
                  32'h0000_2000, 4'b1100, 32'hA5C3_0000, 32'h0, 4'b0000, 32'h0, 1'b0);
        run_store("word", 32'h0000_3000, 32'h1234_5678, 2'b10, 0, 1'b0, 1,
                  32'h0000_3000, 4'b1111, 32'h1234_5678, 32'h0, 4'b0000, 32'h0, 1'b1);
        run_store("half_lo", 32'h0000_3100, 32'hFFFF_8001, 2'b01, 1, 1'b0, 1,
                  32'h0000_3100, 4'b0011, 32'h0000_8001, 32'h0, 4'b0000, 32'h0, 1'b0);
`ifdef RV_STORE_MISALIGN_EN
        run_store("word_cross", 32'h0000_4003, 32'h1122_3344, 2'b10, 0, 1'b0, 2,
                  32'h0000_4000, 4'b1000, 32'h4400_0000, 32'h0000_4004, 4'b0111, 32'h0011_2233, 1'b0);
        run_store("half_mis", 32'h0000_5001, 32'h0000_A5C3, 2'b01, 0, 1'b0, 1,
                  32'h0000_5000, 4'b0110, 32'h00A5_C300, 32'h0, 4'b0000, 32'h0, 1'b0);
        run_store("half_wrap", 32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01, 1, 1'b0, 2,
                  32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000, 32'h0000_0000, 4'b0001, 32'h0000_00BE, 1'b0);
`else
        run_store("word_mis", 32'h0000_4003, 32'h1122_3344, 2'b10, 0, 1'b1, 0,
                  32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
        run_store("half_mis", 32'h0000_5001, 32'h0000_A5C3, 2'b01, 0, 1'b1, 0,
                  32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
`endif
        run_store("illegal", 32'h0000_6000, 32'h5555_AAAA, 2'b11, 0, 1'b1, 0,
                  32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);

        // Reset while waiting for the response abandons the store.
        st_valid = 1'b1;
        st_addr  = 32'h0000_6000;
        st_data  = 32'hCAFE_F00D;
        st_size  = 2'b10;
        step();
        st_valid = 1'b0;
        data_gnt = 1'b1;
        step();
        data_gnt = 1'b0;
        check_eq("arst.in_rsp", 32'(data_req), 32'd0);
        #2;
        arstn = 1'b0;
        #1;
        check_eq("arst.ready", 32'(st_ready), 32'd1);
        check_eq("arst.addr", data_addr, 32'h0);
        check_eq("arst.be", 32'(data_be), 32'h0);
        check_eq("arst.wdata", data_wdata, 32'h0);
        data_rvalid = 1'b1;
        step();
        data_rvalid = 1'b0;
        arstn = 1'b1;
        check_eq("arst.nodone", 32'(st_done), 32'd0);
        step();
        check_eq("arst.nodone2", 32'(st_done), 32'd0);
        check_eq("arst.idle_req", 32'(data_req), 32'd0);
        run_store("post_rst", 32'h0000_8001, 32'h0000_0077, 2'b00, 0, 1'b0, 1,
                  32'h0000_8000, 4'b0010, 32'h0000_7700, 32'h0, 4'b0000, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
